serial_word_collector: RTL and testbench
========================================

Name: serial_word_collector

Overview:
Downstream stage of the 4-bit universal shift register. Samples the register's serial output (S_OUT) one bit per clock while enabled and packs the bits into words. Delivers completed words through a valid/ready handshake with a one-word output buffer. Also keeps a saturating count of bit transitions on the serial line, which feeds the bench's activity/power statistics.

Parameters:
NBITS, 4, nibble width of the upstream shift register
NNIB, 4, nibbles per output word; WORD_W = NBITS*NNIB = 16
CNT_W, 8, width of the transition counter

Ports:
CLK  input  1  system clock, rising edge
RESET  input  1  asynchronous, active-high reset
ENB  input  1  sample enable; a bit is taken on each rising CLK edge with ENB=1
S_IN  input  1  serial data, driven by upstream S_OUT
DIR  input  1  upstream shift direction: 0 = left (MSB first), 1 = right (LSB first)
READY  input  1  consumer accepts Q_OUT this cycle
CLR_OVR  input  1  synchronous clear of OVERRUN
Q_OUT  output  WORD_W  completed word
VALID  output  1  Q_OUT holds an unconsumed word
OVERRUN  output  1  sticky: a completed word was dropped
BIT_CNT  output  clog2(WORD_W)  bits received so far in the current word
TRANS_CNT  output  CNT_W  saturating count of S_IN transitions

Behaviour:
- Reset (async, RESET=1): state=IDLE, shift reg=0, BIT_CNT=0, Q_OUT=0, VALID=0, OVERRUN=0, TRANS_CNT=0, prev_bit=0, dir_lat=0.
- Framing FSM, two states:
  - IDLE: on an edge with ENB=1, latch dir_lat=DIR, take bit 0, set BIT_CNT=1, go to RX.
  - RX: on each edge with ENB=1, take a bit and increment BIT_CNT. The edge that takes bit WORD_W-1 completes the word; BIT_CNT returns to 0 and the FSM returns to IDLE.
  - With ENB=0 the FSM pauses: nothing changes and the word is not aborted.
  - The new word's first bit may arrive on the edge immediately after completion, so back-to-back words need no gap.
- Bit order:
  - dir_lat=0: shift left, new bit enters the LSB, so the first bit ends up at the MSB.
  - dir_lat=1: shift right, new bit enters the MSB, so the first bit ends up at the LSB.
  - DIR changes in mid-word are ignored until the next word starts.
- Output buffer:
  - On a completion edge, the word is written to Q_OUT and VALID=1 is visible after that edge, i.e. latency 1 clock from the last bit sample.
  - Transfer happens on an edge with VALID=1 and READY=1. VALID clears unless a completion happens on the same edge.
  - Completion while VALID=1 and READY=1 on the same edge: Q_OUT takes the new word, VALID stays 1, no overrun.
  - Completion while VALID=1 and READY=0: the new word is dropped, Q_OUT is unchanged, OVERRUN is set to 1.
  - OVERRUN clears only on CLR_OVR=1 or reset. If a set and a clear occur on the same edge, set wins.
  - Q_OUT holds its value after a transfer (not cleared).
- Transition counter:
  - On each edge with ENB=1, if S_IN != prev_bit, TRANS_CNT increments, saturating at 2^CNT_W-1.
  - prev_bit is then updated to S_IN.
  - ENB=0 edges neither count nor update prev_bit.
- Reset asserted mid-word discards the partial word immediately. The first ENB edge after reset release starts a new word.

Test Plan:
1. Reset, then DIR=0, ENB=1, 16 bits of 0xD5A3 MSB first, READY=0 -> VALID=1 one edge after bit 15; Q_OUT=16'hD5A3; BIT_CNT=0; OVERRUN=0.
2. DIR=1, stream of bits 1,0,1,1 repeated four times (LSB first) -> Q_OUT=16'hDDDD; a DIR toggle injected at bit 7 does not change the result.
3. Word A stays pending with READY=0 while word B completes -> OVERRUN=1 and Q_OUT still equals A. Then CLR_OVR=1 -> OVERRUN=0.
4. READY=1 held on the same edge as the next completion while VALID=1 -> Q_OUT updates to the new word, VALID stays 1, OVERRUN stays 0.
5. ENB low for 5 cycles after bit 6, then resume -> BIT_CNT stays at 7 during the pause and the word assembles correctly. Then assert RESET after bit 9 -> BIT_CNT=0, VALID=0, and the next 16 bits form a fresh word.
6. Alternating 0/1 on S_IN for 300 enabled cycles -> TRANS_CNT saturates at 255. Constant S_IN=1 after reset -> TRANS_CNT=1.

Source files
------------

// File: rtl/serial_word_collector.sv
`default_nettype none
// ============================================================================
//  Module      : serial_word_collector
//  Description : Packs the upstream shift register's serial output into
//                16-bit words, hands them out over valid/ready through a
//                one-word buffer and counts serial-line transitions.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_word_collector #(
    parameter int NBITS = 4,
    parameter int NNIB  = 4,
    parameter int CNT_W = 8
) (
    input  logic                              CLK,
    input  logic                              RESET,
    input  logic                              ENB,
    input  logic                              S_IN,
    input  logic                              DIR,
    input  logic                              READY,
    input  logic                              CLR_OVR,
    output logic [NBITS*NNIB-1:0]             Q_OUT,
    output logic                              VALID,
    output logic                              OVERRUN,
    output logic [$clog2(NBITS*NNIB)-1:0]     BIT_CNT,
    output logic [CNT_W-1:0]                  TRANS_CNT
);

    localparam int c_WORD_W = NBITS * NNIB;
    localparam int c_BCNT_W = $clog2(c_WORD_W);

    localparam logic [c_BCNT_W-1:0] c_LAST_BIT  = c_BCNT_W'(c_WORD_W - 1);
    localparam logic [c_BCNT_W-1:0] c_BCNT_ONE  = c_BCNT_W'(1);
    localparam logic [CNT_W-1:0]    c_TRANS_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]    c_TRANS_ONE = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RX   = 1'b1
    } state_t;

    state_t                state_q,   state_d;
    logic [c_WORD_W-1:0]   shift_q,   shift_d;
    logic [c_BCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic                  dir_q,     dir_d;
    logic [c_WORD_W-1:0]   word_q,    word_d;
    logic                  valid_q,   valid_d;
    logic                  ovr_q,     ovr_d;
    logic [CNT_W-1:0]      trans_q,   trans_d;
    logic                  prev_q,    prev_d;

    logic                  w_dir;
    logic [c_WORD_W-1:0]   w_shifted;
    logic                  w_complete;
    logic                  w_ovr_set;

    // The first bit of a word must already use the direction being latched.
    assign w_dir     = (state_q == ST_IDLE) ? DIR : dir_q;
    assign w_shifted = w_dir ? {S_IN, shift_q[c_WORD_W-1:1]}
                             : {shift_q[c_WORD_W-2:0], S_IN};

    // ------------------------------------------------------------------
    // Framing FSM and shift register
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        dir_d      = dir_q;
        w_complete = 1'b0;

        if (ENB) begin
            shift_d = w_shifted;
            case (state_q)
                ST_IDLE: begin
                    dir_d     = DIR;
                    bit_cnt_d = c_BCNT_ONE;
                    state_d   = ST_RX;
                end
                ST_RX: begin
                    if (bit_cnt_q == c_LAST_BIT) begin
                        w_complete = 1'b1;
                        bit_cnt_d  = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + c_BCNT_ONE;
                    end
                end
                default: begin
                    bit_cnt_d = '0;
                    state_d   = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // One-word output buffer with sticky overrun
    // ------------------------------------------------------------------
    always_comb begin
        word_d    = word_q;
        valid_d   = valid_q;
        w_ovr_set = 1'b0;

        if (w_complete) begin
            // A simultaneous transfer frees the buffer for the new word.
            if (!valid_q || READY) begin
                word_d  = w_shifted;
                valid_d = 1'b1;
            end else begin
                w_ovr_set = 1'b1;
            end
        end else if (valid_q && READY) begin
            valid_d = 1'b0;
        end

        if (w_ovr_set) begin
            ovr_d = 1'b1;
        end else if (CLR_OVR) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    // ------------------------------------------------------------------
    // Saturating transition counter
    // ------------------------------------------------------------------
    always_comb begin
        trans_d = trans_q;
        prev_d  = prev_q;

        if (ENB) begin
            if ((S_IN != prev_q) && (trans_q != c_TRANS_MAX)) begin
                trans_d = trans_q + c_TRANS_ONE;
            end
            prev_d = S_IN;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            dir_q     <= 1'b0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            ovr_q     <= 1'b0;
            trans_q   <= '0;
            prev_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            dir_q     <= dir_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
            ovr_q     <= ovr_d;
            trans_q   <= trans_d;
            prev_q    <= prev_d;
        end
    end

    assign Q_OUT     = word_q;
    assign VALID     = valid_q;
    assign OVERRUN   = ovr_q;
    assign BIT_CNT   = bit_cnt_q;
    assign TRANS_CNT = trans_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_word_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_word_collector
//  Description : Self-checking bench for serial_word_collector against a
//                queue-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_word_collector;

    localparam int c_W = 16;

    logic        CLK;
    logic        RESET;
    logic        ENB;
    logic        S_IN;
    logic        DIR;
    logic        READY;
    logic        CLR_OVR;
    logic [15:0] Q_OUT;
    logic        VALID;
    logic        OVERRUN;
    logic [3:0]  BIT_CNT;
    logic [7:0]  TRANS_CNT;

    serial_word_collector #(
        .NBITS (4),
        .NNIB  (4),
        .CNT_W (8)
    ) u_dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .ENB       (ENB),
        .S_IN      (S_IN),
        .DIR       (DIR),
        .READY     (READY),
        .CLR_OVR   (CLR_OVR),
        .Q_OUT     (Q_OUT),
        .VALID     (VALID),
        .OVERRUN   (OVERRUN),
        .BIT_CNT   (BIT_CNT),
        .TRANS_CNT (TRANS_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: bits of the word in progress, in arrival order
    bit          m_bits[$];
    bit          m_dir;
    logic [15:0] m_q;
    bit          m_valid;
    bit          m_ovr;
    bit          m_prev;
    int          m_trans;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_dir   = 1'b0;
        m_q     = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_prev  = 1'b0;
        m_trans = 0;
    endtask

    task automatic model_edge();
        logic [15:0] word;
        bit done;
        bit set;
        word = '0;
        done = 1'b0;
        set  = 1'b0;
        if (ENB) begin
            if (m_bits.size() == 0) m_dir = DIR;
            m_bits.push_back(S_IN);
            if ((S_IN != m_prev) && (m_trans < 255)) m_trans++;
            m_prev = S_IN;
            if (m_bits.size() == c_W) begin
                for (int i = 0; i < c_W; i++) begin
                    if (m_dir) word[i] = m_bits[i];
                    else       word[c_W-1-i] = m_bits[i];
                end
                m_bits.delete();
                done = 1'b1;
            end
        end
        if (done) begin
            if (!m_valid || READY) begin
                m_q     = word;
                m_valid = 1'b1;
            end else begin
                set = 1'b1;
            end
        end else if (m_valid && READY) begin
            m_valid = 1'b0;
        end
        if (set)          m_ovr = 1'b1;
        else if (CLR_OVR) m_ovr = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".bit_cnt"}, 32'(BIT_CNT),   32'(m_bits.size()));
        check({tag, ".valid"},   32'(VALID),     32'(m_valid));
        check({tag, ".q_out"},   32'(Q_OUT),     32'(m_q));
        check({tag, ".overrun"}, 32'(OVERRUN),   32'(m_ovr));
        check({tag, ".trans"},   32'(TRANS_CNT), 32'(m_trans));
    endtask

    task automatic step(input string tag);
        @(posedge CLK);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input bit e, input bit s, input bit d, input bit r, input bit c,
                         input string tag);
        ENB     = e;
        S_IN    = s;
        DIR     = d;
        READY   = r;
        CLR_OVR = c;
        step(tag);
    endtask

    // Called between edges; reset is asynchronous so outputs clear at once.
    task automatic do_reset(input string tag);
        RESET = 1'b1;
        #2;
        model_reset();
        check_all(tag);
        RESET = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w, input bit d, input bit r, input string tag);
        for (int i = 0; i < c_W; i++) begin
            drive(1'b1, d ? w[i] : w[c_W-1-i], d, r, 1'b0, tag);
        end
    endtask

    task automatic consume();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "consume");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, time %0t, limit 200000", $time);
        $fatal(1, "watchdog");
    end

    bit          seq[4];
    logic [15:0] wa;
    logic [15:0] wb;
    logic [15:0] wc;

    initial begin
        RESET   = 1'b0;
        ENB     = 1'b0;
        S_IN    = 1'b0;
        DIR     = 1'b0;
        READY   = 1'b0;
        CLR_OVR = 1'b0;
        model_reset();
        #1;
        do_reset("reset");
        check("reset.q_out_zero", 32'(Q_OUT), 32'h0);

        // 1: MSB-first word
        send_word(16'hD5A3, 1'b0, 1'b0, "t1");
        check("t1.valid",   32'(VALID),   32'd1);
        check("t1.word",    32'(Q_OUT),   32'hD5A3);
        check("t1.bit_cnt", 32'(BIT_CNT), 32'd0);
        check("t1.overrun", 32'(OVERRUN), 32'd0);
        consume();
        check("t1.consumed", 32'(VALID), 32'd0);
        check("t1.hold_q",   32'(Q_OUT), 32'hD5A3);

        // 2: LSB-first stream with a DIR glitch mid-word
        seq = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < c_W; i++) begin
            drive(1'b1, seq[i%4], (i == 7) ? 1'b0 : 1'b1, 1'b0, 1'b0, "t2");
        end
        check("t2.word", 32'(Q_OUT), 32'hDDDD);
        consume();

        // 3: overrun while a word is pending
        wa = 16'($urandom);
        wb = 16'($urandom);
        send_word(wa, 1'b0, 1'b0, "t3a");
        send_word(wb, 1'b1, 1'b0, "t3b");
        check("t3.overrun", 32'(OVERRUN), 32'd1);
        check("t3.keep_a",  32'(Q_OUT),   32'(wa));
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "t3clr");
        check("t3.cleared", 32'(OVERRUN), 32'd0);

        // 4: completion coincident with a transfer
        wc = wa ^ 16'hFFFF;
        for (int i = 0; i < c_W; i++) begin
            drive(1'b1, wc[c_W-1-i], 1'b0, (i == c_W-1), 1'b0, "t4");
        end
        check("t4.word",    32'(Q_OUT),   32'(wc));
        check("t4.valid",   32'(VALID),   32'd1);
        check("t4.overrun", 32'(OVERRUN), 32'd0);
        consume();

        // 5: pause mid-word, then reset mid-word
        wa = 16'($urandom);
        for (int i = 0; i < 7; i++) drive(1'b1, wa[c_W-1-i], 1'b0, 1'b0, 1'b0, "t5");
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, ~wa[c_W-1-i], 1'b1, 1'b0, 1'b0, "t5pause");
            check("t5.pause_cnt", 32'(BIT_CNT), 32'd7);
        end
        for (int i = 7; i < c_W; i++) drive(1'b1, wa[c_W-1-i], 1'b0, 1'b0, 1'b0, "t5");
        check("t5.word", 32'(Q_OUT), 32'(wa));
        consume();
        wb = 16'($urandom);
        for (int i = 0; i < 10; i++) drive(1'b1, wb[i], 1'b1, 1'b0, 1'b0, "t5b");
        do_reset("t5rst");
        check("t5.rst_cnt",   32'(BIT_CNT), 32'd0);
        check("t5.rst_valid", 32'(VALID),   32'd0);
        wc = 16'($urandom);
        send_word(wc, 1'b1, 1'b0, "t5c");
        check("t5.fresh", 32'(Q_OUT), 32'(wc));

        // 6: transition counter saturation and single transition
        do_reset("t6rst");
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, (i % 2) == 0, 1'b0, 1'b1, 1'b0, "t6alt");
        end
        check("t6.saturate", 32'(TRANS_CNT), 32'd255);
        do_reset("t6rst2");
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "t6const");
        check("t6.const", 32'(TRANS_CNT), 32'd1);

        // Random traffic
        do_reset("rnd_rst");
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0, "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
